// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential 128-bit adder.
package alu_pkg;

  localparam int DATA_W      = 128;
  localparam int SLICE_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
    logic sign;
  } raw_flags_t;

  localparam raw_flags_t FLAGS_RST = '{cout: 1'b0, ovf: 1'b0, zero: 1'b1, sign: 1'b0};

  // The slice index has to reach N itself, because that is the commit beat.
  function automatic int idx_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/alu_slice_add.sv
// Combinational W-bit adder slice. It also reports the carry into its MSB,
// which is used to derive signed overflow on the top slice.
module alu_slice_add #(
  parameter int W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         ci_i,
  output logic [W-1:0] sum_o,
  output logic         co_o,
  output logic         c_msb_o
);

  // Ripple sum plus carry out; the carry into the MSB is recovered from the MSB sum bit.
  always_comb begin
    {co_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, ci_i};
    c_msb_o       = a_i[W-1] ^ b_i[W-1] ^ sum_o[W-1];
  end

endmodule

// File: rtl/seq_add_128.sv
// Sequential 128-bit add/subtract, one SLICE_W-bit slice per cycle, LSB first.
//
//   state   | meaning
//   --------+-----------------------------------------------------------------
//   IDLE    | waiting for start; outputs hold the last completed result
//   RUN     | idx 0..N-1 add one slice each; idx N commits to the outputs
//   DONE    | one-cycle done pulse; start here is accepted back-to-back
//
// Partial sums are built in a working register and only copied to the
// output registers on the commit beat. Flush or start-in-RUN therefore
// never disturbs result or the flags, and "restore on flush" costs nothing.
module seq_add_128
  import alu_pkg::*;
#(
  parameter int SLICE_W = SLICE_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              flush,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              mode,
  input  logic              cin,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              cout,
  output logic              ovf,
  output logic              zero,
  output logic              sign
);

  localparam int              N        = DATA_W / SLICE_W;
  localparam int              IDX_W    = idx_width(N);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N);

  state_e             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic               busy_q;
  logic               done_q;
  logic [DATA_W-1:0]  result_q;
  raw_flags_t         flags_q;

  logic [DATA_W-1:0]  op_a_q, op_a_d;
  logic [DATA_W-1:0]  op_b_q, op_b_d;
  logic               carry_q, carry_d;
  logic [DATA_W-1:0]  work_q, work_d;
  logic               zacc_q, zacc_d;
  logic               wovf_q, wovf_d;

  logic [SLICE_W-1:0] s_sum;
  logic               s_co;
  logic               s_cmsb;
  logic               start_acc;
  logic               slice_en;

  assign start_acc = start & ~flush & (state_q != ST_RUN);
  assign slice_en  = (state_q == ST_RUN) & (idx_q != IDX_LAST);

  // Operands shift right each beat, so the active slice always sits at bit 0.
  alu_slice_add #(.W(SLICE_W)) u_slice (
    .a_i     (op_a_q[SLICE_W-1:0]),
    .b_i     (op_b_q[SLICE_W-1:0]),
    .ci_i    (carry_q),
    .sum_o   (s_sum),
    .co_o    (s_co),
    .c_msb_o (s_cmsb)
  );

  // Datapath next state: capture on accepted start, otherwise advance one slice per RUN beat.
  always_comb begin
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    carry_d = carry_q;
    work_d  = work_q;
    zacc_d  = zacc_q;
    wovf_d  = wovf_q;
    if (start_acc) begin
      op_a_d  = a;
      op_b_d  = mode ? ~b : b;
      carry_d = cin;
      work_d  = '0;
      zacc_d  = 1'b1;
      wovf_d  = 1'b0;
    end else if (slice_en) begin
      op_a_d  = op_a_q >> SLICE_W;
      op_b_d  = op_b_q >> SLICE_W;
      carry_d = s_co;
      work_d  = (work_q >> SLICE_W) | (DATA_W'(s_sum) << (DATA_W - SLICE_W));
      zacc_d  = zacc_q & ~(|s_sum);
      wovf_d  = s_cmsb ^ s_co;
    end
  end

  // Control FSM with registered busy/done, working registers and committed outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      flags_q  <= FLAGS_RST;
      op_a_q   <= '0;
      op_b_q   <= '0;
      carry_q  <= 1'b0;
      work_q   <= '0;
      zacc_q   <= 1'b1;
      wovf_q   <= 1'b0;
    end else begin
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      carry_q <= carry_d;
      work_q  <= work_d;
      zacc_q  <= zacc_d;
      wovf_q  <= wovf_d;
      done_q  <= 1'b0;
      if (flush) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start) begin
              state_q <= ST_RUN;
              idx_q   <= '0;
              busy_q  <= 1'b1;
            end
          end
          ST_RUN: begin
            if (idx_q == IDX_LAST) begin
              state_q  <= ST_DONE;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              result_q <= work_q;
              flags_q  <= '{cout: carry_q, ovf: wovf_q, zero: zacc_q,
                            sign: work_q[DATA_W-1]};
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
          ST_DONE: begin
            if (start) begin
              state_q <= ST_RUN;
              idx_q   <= '0;
              busy_q  <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout   = flags_q.cout;
  assign ovf    = flags_q.ovf;
  assign zero   = flags_q.zero;
  assign sign   = flags_q.sign;

endmodule
